// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared register indices, FSM states and AXI constants for the DMA slave
package dma_pkg;

    localparam int REG_W = 32;

    localparam logic [2:0] DMAEN_IDX  = 3'd0;
    localparam logic [2:0] DMASRC_IDX = 3'd1;
    localparam logic [2:0] DMADST_IDX = 3'd2;
    localparam logic [2:0] DMALEN_IDX = 3'd3;
    localparam logic [2:0] STATUS_IDX = 3'd4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2,
        RDATA = 2'd3
    } state_t;

    // Word index only moves for INCR; every other burst type behaves as FIXED.
    function automatic logic [2:0] next_idx(input logic [2:0] idx, input logic [1:0] burst);
        return (burst == BURST_INCR) ? idx + 3'd1 : idx;
    endfunction

endpackage

// File: rtl/dma_reg_file.sv
// rtl/dma_reg_file.sv - DMA control registers with byte-strobed write and combinational read mux
module dma_reg_file
    import dma_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [2:0]       wr_idx,
    input  logic [REG_W-1:0] wr_data,
    input  logic [3:0]       wr_strb,
    input  logic [2:0]       rd_idx,
    input  logic             irq,
    output logic [REG_W-1:0] rd_data,
    output logic             dmaen,
    output logic [REG_W-1:0] dmasrc,
    output logic [REG_W-1:0] dmadst,
    output logic [REG_W-1:0] dmalen
);

    function automatic logic [REG_W-1:0] merge(input logic [REG_W-1:0] old,
                                               input logic [REG_W-1:0] data,
                                               input logic [3:0]       strb);
        logic [REG_W-1:0] res;
        res = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = data[8*b +: 8];
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            dmaen  <= 1'b0;
            dmasrc <= '0;
            dmadst <= '0;
            dmalen <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                DMAEN_IDX:  if (wr_strb[0]) dmaen <= wr_data[0];
                DMASRC_IDX: dmasrc <= merge(dmasrc, wr_data, wr_strb);
                DMADST_IDX: dmadst <= merge(dmadst, wr_data, wr_strb);
                DMALEN_IDX: dmalen <= merge(dmalen, wr_data, wr_strb);
                default: ;
            endcase
        end
    end

    // STATUS is read-only and indices 5-7 read as zero.
    always_comb begin
        rd_data = '0;
        case (rd_idx)
            DMAEN_IDX:  rd_data = {{(REG_W-1){1'b0}}, dmaen};
            DMASRC_IDX: rd_data = dmasrc;
            DMADST_IDX: rd_data = dmadst;
            DMALEN_IDX: rd_data = dmalen;
            STATUS_IDX: rd_data = {{(REG_W-1){1'b0}}, irq};
            default:    rd_data = '0;
        endcase
    end

endmodule

// File: rtl/dma_slave_regs.sv
// rtl/dma_slave_regs.sv - AXI slave port exposing the DMA control and status registers
module dma_slave_regs
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   S_AWID,
    input  logic [ADDR_W-1:0] S_AWAddr,
    input  logic [LEN_W-1:0]  S_AWLen,
    input  logic [2:0]        S_AWSize,
    input  logic [1:0]        S_AWBurst,
    input  logic              S_AWValid,
    output logic              S_AWReady,
    input  logic [DATA_W-1:0] S_WData,
    input  logic [3:0]        S_WStrb,
    input  logic              S_WLast,
    input  logic              S_WValid,
    output logic              S_WReady,
    output logic [ID_W-1:0]   S_BID,
    output logic [1:0]        S_BResp,
    output logic              S_BValid,
    input  logic              S_BReady,
    input  logic [ID_W-1:0]   S_ARID,
    input  logic [ADDR_W-1:0] S_ARAddr,
    input  logic [LEN_W-1:0]  S_ARLen,
    input  logic [2:0]        S_ARSize,
    input  logic [1:0]        S_ARBurst,
    input  logic              S_ARValid,
    output logic              S_ARReady,
    output logic [ID_W-1:0]   S_RID,
    output logic [DATA_W-1:0] S_RData,
    output logic [1:0]        S_RResp,
    output logic              S_RLast,
    output logic              S_RValid,
    input  logic              S_RReady,
    input  logic              DMA_interrupt,
    output logic              DMAEN,
    output logic [31:0]       DMASRC,
    output logic [31:0]       DMADST,
    output logic [31:0]       DMALEN
);

    state_t            state;
    logic [ID_W-1:0]   id_q;
    logic [2:0]        idx_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [1:0]        burst_q;
    logic [REG_W-1:0]  rd_data;
    logic              wr_en;

    // Only the word index matters; size and the other address bits are accepted but unused.
    logic unused_bits;
    assign unused_bits = ^{S_AWAddr[ADDR_W-1:5], S_AWAddr[1:0], S_AWSize,
                           S_ARAddr[ADDR_W-1:5], S_ARAddr[1:0], S_ARSize};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            id_q    <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            cnt     <= '0;
            burst_q <= BURST_FIXED;
        end else begin
            case (state)
                IDLE: begin
                    if (S_AWValid) begin
                        id_q    <= S_AWID;
                        idx_q   <= S_AWAddr[4:2];
                        len_q   <= S_AWLen;
                        burst_q <= S_AWBurst;
                        cnt     <= '0;
                        state   <= WDATA;
                    end else if (S_ARValid) begin
                        id_q    <= S_ARID;
                        idx_q   <= S_ARAddr[4:2];
                        len_q   <= S_ARLen;
                        burst_q <= S_ARBurst;
                        cnt     <= '0;
                        state   <= RDATA;
                    end
                end
                WDATA: begin
                    if (S_WValid) begin
                        idx_q <= next_idx(idx_q, burst_q);
                        cnt   <= cnt + LEN_W'(1);
                        if (S_WLast) begin
                            state <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (S_BReady) begin
                        state <= IDLE;
                    end
                end
                RDATA: begin
                    if (S_RReady) begin
                        idx_q <= next_idx(idx_q, burst_q);
                        cnt   <= cnt + LEN_W'(1);
                        if (cnt == len_q) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode from state; gating with rst keeps them low while reset is held.
    assign S_AWReady = rst && (state == IDLE);
    assign S_ARReady = rst && (state == IDLE) && !S_AWValid;
    assign S_WReady  = rst && (state == WDATA);
    assign S_BValid  = rst && (state == WRESP);
    assign S_BID     = S_BValid ? id_q : '0;
    assign S_BResp   = RESP_OKAY;
    assign S_RValid  = rst && (state == RDATA);
    assign S_RID     = S_RValid ? id_q : '0;
    assign S_RData   = S_RValid ? rd_data : '0;
    assign S_RLast   = S_RValid && (cnt == len_q);
    assign S_RResp   = RESP_OKAY;

    assign wr_en = (state == WDATA) && S_WValid;

    dma_reg_file u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_data (S_WData),
        .wr_strb (S_WStrb),
        .rd_idx  (idx_q),
        .irq     (DMA_interrupt),
        .rd_data (rd_data),
        .dmaen   (DMAEN),
        .dmasrc  (DMASRC),
        .dmadst  (DMADST),
        .dmalen  (DMALEN)
    );

endmodule

// File: tb/tb_dma_slave_regs.sv
// tb/tb_dma_slave_regs.sv - scoreboard bench for the DMA register slave
module tb_dma_slave_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  S_AWID, S_ARID, S_BID, S_RID;
    logic [31:0] S_AWAddr, S_ARAddr, S_WData, S_RData;
    logic [3:0]  S_AWLen, S_ARLen, S_WStrb;
    logic [2:0]  S_AWSize, S_ARSize;
    logic [1:0]  S_AWBurst, S_ARBurst, S_BResp, S_RResp;
    logic        S_AWValid, S_AWReady, S_WLast, S_WValid, S_WReady;
    logic        S_BValid, S_BReady, S_ARValid, S_ARReady;
    logic        S_RLast, S_RValid, S_RReady;
    logic        DMA_interrupt, DMAEN;
    logic [31:0] DMASRC, DMADST, DMALEN;

    always #5 clk = ~clk;

    dma_slave_regs dut (
        .clk(clk), .rst(rst),
        .S_AWID(S_AWID), .S_AWAddr(S_AWAddr), .S_AWLen(S_AWLen), .S_AWSize(S_AWSize),
        .S_AWBurst(S_AWBurst), .S_AWValid(S_AWValid), .S_AWReady(S_AWReady),
        .S_WData(S_WData), .S_WStrb(S_WStrb), .S_WLast(S_WLast), .S_WValid(S_WValid),
        .S_WReady(S_WReady),
        .S_BID(S_BID), .S_BResp(S_BResp), .S_BValid(S_BValid), .S_BReady(S_BReady),
        .S_ARID(S_ARID), .S_ARAddr(S_ARAddr), .S_ARLen(S_ARLen), .S_ARSize(S_ARSize),
        .S_ARBurst(S_ARBurst), .S_ARValid(S_ARValid), .S_ARReady(S_ARReady),
        .S_RID(S_RID), .S_RData(S_RData), .S_RResp(S_RResp), .S_RLast(S_RLast),
        .S_RValid(S_RValid), .S_RReady(S_RReady),
        .DMA_interrupt(DMA_interrupt), .DMAEN(DMAEN), .DMASRC(DMASRC),
        .DMADST(DMADST), .DMALEN(DMALEN)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  bq[$];
    logic [40:0] rq[$];
    logic [31:0] mdl[0:3];
    logic [31:0] wd[0:15];
    logic [3:0]  ws[0:15];

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 4; i++) mdl[i] = '0;
    endfunction

    function automatic void m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        if (idx < 4) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
            end
            if (idx == 0) mdl[0][31:1] = '0;
        end
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx < 4) return mdl[idx];
        if (idx == 4) return {31'b0, DMA_interrupt};
        return 32'h0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_dmaen"}, DMAEN, mdl[0][0]);
        check({tag, "_dmasrc"}, DMASRC, mdl[1]);
        check({tag, "_dmadst"}, DMADST, mdl[2]);
        check({tag, "_dmalen"}, DMALEN, mdl[3]);
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int bhold);
        int idx;
        int t;
        idx = int'(addr[4:2]);
        S_AWID = id; S_AWAddr = addr; S_AWLen = len; S_AWBurst = burst; S_AWValid = 1'b1;
        t = 0;
        while (!S_AWReady && t < 50) begin cyc(); t++; end
        check("aw_ready", S_AWReady, 1);
        cyc();
        S_AWValid = 1'b0;
        bq.push_back(id);
        for (int b = 0; b <= int'(len); b++) begin
            S_WData = wd[b]; S_WStrb = ws[b]; S_WLast = (b == int'(len)); S_WValid = 1'b1;
            t = 0;
            while (!S_WReady && t < 50) begin cyc(); t++; end
            cyc();
            m_write(idx, wd[b], ws[b]);
            check_regs("w_beat");
            if (burst == 2'b01) idx = (idx + 1) % 8;
        end
        S_WValid = 1'b0; S_WLast = 1'b0;
        check("b_valid_latency", S_BValid, 1);
        if (bhold > 0) begin
            S_BReady = 1'b0;
            repeat (bhold) begin
                cyc();
                check("b_hold", S_BValid, 1);
            end
            S_BReady = 1'b1;
        end
        t = 0;
        while (S_BValid && t < 50) begin cyc(); t++; end
        check("b_done", S_BValid, 0);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit toggle);
        int idx;
        int t;
        idx = int'(addr[4:2]);
        for (int b = 0; b <= int'(len); b++) begin
            rq.push_back({(b == int'(len)), id, m_read(idx)});
            if (burst == 2'b01) idx = (idx + 1) % 8;
        end
        S_ARID = id; S_ARAddr = addr; S_ARLen = len; S_ARBurst = burst; S_ARValid = 1'b1;
        t = 0;
        while (!S_ARReady && t < 50) begin cyc(); t++; end
        check("ar_ready", S_ARReady, 1);
        cyc();
        S_ARValid = 1'b0;
        for (int n = 0; n < 200; n++) begin
            S_RReady = toggle ? (n % 2 == 1) : 1'b1;
            cyc();
            if (rq.size() == 0) break;
        end
        S_RReady = 1'b0;
        check("r_drained", rq.size(), 0);
        check("r_idle_after_last", S_RValid, 0);
    endtask

    // Scoreboard monitor: compares every presented response against the queued expectation.
    always @(negedge clk) begin
        logic [40:0] e;
        if (rst) begin
            if (S_BValid && S_BReady) begin
                if (bq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_unexpected: got id %0h expected none", S_BID);
                end else begin
                    check("b_id", S_BID, bq.pop_front());
                    check("b_resp", S_BResp, 2'b00);
                end
            end
            if (S_RValid) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL r_unexpected: got data %0h expected none", S_RData);
                end else begin
                    e = rq[0];
                    check("r_data", S_RData, e[31:0]);
                    check("r_id", S_RID, e[39:32]);
                    check("r_last", S_RLast, e[40]);
                    check("r_resp", S_RResp, 2'b00);
                    if (S_RReady) void'(rq.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        S_AWID = '0; S_AWAddr = '0; S_AWLen = '0; S_AWSize = 3'b010; S_AWBurst = 2'b01;
        S_AWValid = 1'b0; S_WData = '0; S_WStrb = '0; S_WLast = 1'b0; S_WValid = 1'b0;
        S_BReady = 1'b1;
        S_ARID = '0; S_ARAddr = '0; S_ARLen = '0; S_ARSize = 3'b010; S_ARBurst = 2'b01;
        S_ARValid = 1'b0; S_RReady = 1'b0; DMA_interrupt = 1'b0;
        m_reset();
        repeat (3) cyc();
        check("rst_awready", S_AWReady, 0);
        check("rst_arready", S_ARReady, 0);
        check("rst_wready", S_WReady, 0);
        check("rst_bvalid", S_BValid, 0);
        check("rst_rvalid", S_RValid, 0);
        check("rst_rlast", S_RLast, 0);
        check("rst_rdata", S_RData, 0);
        check_regs("rst");
        rst = 1'b1;
        cyc();
        check("idle_awready", S_AWReady, 1);

        // Single write to DMASRC
        wd[0] = 32'h0000_1000; ws[0] = 4'hF;
        do_write(8'h11, 32'h4, 4'd0, 2'b01, 0);
        check("t1_dmasrc", DMASRC, 32'h0000_1000);

        // INCR burst over SRC/DST/LEN, then enable with a held B
        wd[0] = 32'h1000; wd[1] = 32'h2000; wd[2] = 32'h10;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        do_write(8'h22, 32'h4, 4'd2, 2'b01, 0);
        check("t2_dmasrc", DMASRC, 32'h1000);
        check("t2_dmadst", DMADST, 32'h2000);
        check("t2_dmalen", DMALEN, 32'h10);
        wd[0] = 32'h1;
        do_write(8'h23, 32'h0, 4'd0, 2'b01, 2);
        check("t2_dmaen", DMAEN, 1);

        // Partial strobe on DMALEN
        wd[0] = 32'h1234_5678; ws[0] = 4'hF;
        do_write(8'h30, 32'hC, 4'd0, 2'b01, 0);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0011;
        do_write(8'h31, 32'hC, 4'd0, 2'b01, 0);
        check("t3_dmalen_strb", DMALEN, 32'h1234_CCDD);

        // Writes to STATUS and unmapped words leave everything alone
        wd[0] = 32'hFFFF_FFFF; wd[1] = 32'hFFFF_FFFF; wd[2] = 32'hFFFF_FFFF;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        do_write(8'h32, 32'h10, 4'd2, 2'b01, 0);
        check("t3_dmalen_kept", DMALEN, 32'h1234_CCDD);

        // INCR read of all five registers with RReady toggling
        DMA_interrupt = 1'b1;
        do_read(8'h44, 32'h0, 4'd4, 2'b01, 1'b1);

        // Simultaneous AW/AR: the write wins and the read follows the B handshake
        S_ARID = 8'h55; S_ARAddr = 32'h18; S_ARLen = 4'd0; S_ARBurst = 2'b01; S_ARValid = 1'b1;
        S_AWID = 8'h54; S_AWAddr = 32'h14; S_AWLen = 4'd0; S_AWBurst = 2'b01; S_AWValid = 1'b1;
        #1;
        check("t5_awready", S_AWReady, 1);
        check("t5_arready", S_ARReady, 0);
        wd[0] = 32'h5A5A_5A5A; ws[0] = 4'hF;
        do_write(8'h54, 32'h14, 4'd0, 2'b01, 0);
        do_read(8'h55, 32'h18, 4'd0, 2'b01, 1'b0);

        // FIXED burst writes and reads the same word
        wd[0] = 32'hA; wd[1] = 32'hB; ws[0] = 4'hF; ws[1] = 4'hF;
        do_write(8'h60, 32'h8, 4'd1, 2'b00, 0);
        check("fixed_dmadst", DMADST, 32'hB);
        do_read(8'h61, 32'h8, 4'd2, 2'b00, 1'b0);

        // Reset asserted while the second read beat is presented
        rq.push_back({1'b0, 8'h66, m_read(0)});
        S_ARID = 8'h66; S_ARAddr = 32'h0; S_ARLen = 4'd4; S_ARBurst = 2'b01; S_ARValid = 1'b1;
        for (int t = 0; t < 50 && !S_ARReady; t++) cyc();
        cyc();
        S_ARValid = 1'b0;
        S_RReady = 1'b1;
        cyc();
        check("t6_beat2_valid", S_RValid, 1);
        rst = 1'b0;
        cyc();
        S_RReady = 1'b0;
        m_reset();
        check("t6_rvalid", S_RValid, 0);
        check("t6_queue", rq.size(), 0);
        check_regs("t6");
        rst = 1'b1;
        cyc();
        check("t6_idle_awready", S_AWReady, 1);
        do_read(8'h77, 32'h0, 4'd4, 2'b01, 1'b0);

        repeat (2) cyc();
        check("b_queue_empty", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
